// File: rtl/reflex_ctrl.sv
// Reflex-game control FSM: arms the penalty wait via wait_count, lights the LED, times the reaction.
// Optional REFLEX_PENALTY_EN: early presses grow errors and lengthen the next wait.
module reflex_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int WAIT_TICKS = 250,
  parameter int TIMEOUT_MS = 999,
  parameter int MS_W       = 10
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            start,
  input  logic            button,
  input  logic            end_wait,
  output logic            load_wait,
  output logic            dec_wait,
  output logic [1:0]      new_error_count,
  output logic            led,
  output logic [MS_W-1:0] reaction_ms,
  output logic            result_valid,
  output logic            too_slow,
  output logic            early,
  output logic [1:0]      errors
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_LIGHT = 2'd3;

  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int STEP_W = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic              button_q;
  logic [PRE_W-1:0]  prescale_r;
  logic [STEP_W-1:0] step_r;
  logic [MS_W-1:0]   ms_cnt_r;
  logic [1:0]        errors_r;
  logic [MS_W-1:0]   reaction_r;
  logic              result_valid_r;
  logic              too_slow_r;
  logic              early_r;

  logic press_s;
  logic ms_tick_s;
  logic step_last_s;
  logic timeout_s;
  logic go_light_s;
  logic counting_s;

  assign press_s     = button & ~button_q;
  assign ms_tick_s   = (prescale_r == PRE_W'(TICK_DIV - 1));
  assign step_last_s = (step_r == STEP_W'(WAIT_TICKS - 1));
  assign timeout_s   = ms_tick_s && (ms_cnt_r == MS_W'(TIMEOUT_MS - 1));
  assign go_light_s  = (state_r == ST_WAIT) && !press_s && end_wait;
  assign counting_s  = (state_r == ST_WAIT) || (state_r == ST_LIGHT);

  // Next-state selection; a press always wins over end_wait and timeout.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:  if (start) state_nxt_s = ST_LOAD; else state_nxt_s = ST_IDLE;
      ST_LOAD:  state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (press_s)       state_nxt_s = ST_LOAD;
        else if (end_wait) state_nxt_s = ST_LIGHT;
        else               state_nxt_s = ST_WAIT;
      end
      ST_LIGHT: if (press_s || timeout_s) state_nxt_s = ST_IDLE; else state_nxt_s = ST_LIGHT;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // Command lines to wait_count and the LED, decoded from the state registers.
  always_comb begin
    load_wait       = 1'b0;
    dec_wait        = 1'b0;
    new_error_count = 2'd0;
    led             = 1'b0;
    case (state_r)
      ST_LOAD: begin
        load_wait       = 1'b1;
        new_error_count = sat_inc2(errors_r);
      end
      ST_WAIT:  dec_wait = ms_tick_s && step_last_s && !press_s;
      ST_LIGHT: led = 1'b1;
      default: begin
        load_wait = 1'b0;
      end
    endcase
  end

  // State, counters, result registers and one-cycle event pulses.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      button_q       <= 1'b1;
      prescale_r     <= '0;
      step_r         <= '0;
      ms_cnt_r       <= '0;
      errors_r       <= 2'd0;
      reaction_r     <= '0;
      result_valid_r <= 1'b0;
      too_slow_r     <= 1'b0;
      early_r        <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      button_q       <= button;
      result_valid_r <= 1'b0;
      too_slow_r     <= 1'b0;
      early_r        <= 1'b0;

      if (counting_s && !go_light_s)
        prescale_r <= ms_tick_s ? '0 : prescale_r + PRE_W'(1);
      else
        prescale_r <= '0;

      if (state_r == ST_LOAD)
        step_r <= '0;
      else if ((state_r == ST_WAIT) && ms_tick_s)
        step_r <= step_last_s ? '0 : step_r + STEP_W'(1);

      if (go_light_s)
        ms_cnt_r <= '0;
      else if ((state_r == ST_LIGHT) && ms_tick_s)
        ms_cnt_r <= ms_cnt_r + MS_W'(1);

      if ((state_r == ST_WAIT) && press_s) begin
        early_r <= 1'b1;
`ifdef REFLEX_PENALTY_EN
        errors_r <= sat_inc2(errors_r);
`else
        errors_r <= 2'd0;
`endif
      end

      if ((state_r == ST_LIGHT) && press_s) begin
        reaction_r     <= ms_cnt_r;
        result_valid_r <= 1'b1;
        errors_r       <= 2'd0;
      end else if ((state_r == ST_LIGHT) && timeout_s) begin
        reaction_r <= '1;
        too_slow_r <= 1'b1;
      end
    end
  end

  assign reaction_ms  = reaction_r;
  assign result_valid = result_valid_r;
  assign too_slow     = too_slow_r;
  assign early        = early_r;
  assign errors       = errors_r;

endmodule
